// File: rtl/aclock_setter_if.sv
// Purpose: bundles the button, time-snapshot and load/edit signals exchanged
//          between the button conditioner, the aclock setter and aclock.
// Signals:
//   btn_time/btn_alarm/btn_inc/btn_next/btn_stop  debounced button levels
//   H_out1/H_out0/M_out1/M_out0                   current aclock time (BCD)
//   H_in1/H_in0/M_in1/M_in0                       edit digits toward aclock
//   LD_time/LD_alarm                              load strobes
//   STOP_al                                       single-cycle stop-alarm pulse
//   edit_active/edit_digit/edit_alarm             edit status
// Modports: master = the setter, slave = the surrounding board/aclock side.
interface aclock_setter_if;
  logic       btn_time;
  logic       btn_alarm;
  logic       btn_inc;
  logic       btn_next;
  logic       btn_stop;
  logic [1:0] H_out1;
  logic [3:0] H_out0;
  logic [3:0] M_out1;
  logic [3:0] M_out0;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       STOP_al;
  logic       edit_active;
  logic [1:0] edit_digit;
  logic       edit_alarm;

  modport master (
    input  btn_time, btn_alarm, btn_inc, btn_next, btn_stop,
    input  H_out1, H_out0, M_out1, M_out0,
    output H_in1, H_in0, M_in1, M_in0,
    output LD_time, LD_alarm, STOP_al,
    output edit_active, edit_digit, edit_alarm
  );

  modport slave (
    output btn_time, btn_alarm, btn_inc, btn_next, btn_stop,
    output H_out1, H_out0, M_out1, M_out0,
    input  H_in1, H_in0, M_in1, M_in0,
    input  LD_time, LD_alarm, STOP_al,
    input  edit_active, edit_digit, edit_alarm
  );
endinterface

// File: rtl/aclock_setter.sv
// Purpose: user-side configuration master for aclock. Converts debounced button
//          levels into BCD HH:MM digit edits and loads them into aclock as time
//          or alarm; also issues stop-alarm pulses.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    aclock_setter_if.master (buttons, time snapshot, digits, strobes, status)
// Parameters:
//   LD_PULSE_CYC  strobe length in cycles (>=1)
//   TIMEOUT_CYC   idle cycles in an edit state before auto-abort (0 = never)
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for a time or alarm press
// EDIT_H1 | editing tens of hours
// EDIT_H0 | editing units of hours
// EDIT_M1 | editing tens of minutes
// EDIT_M0 | editing units of minutes
// LOAD    | driving LD_time/LD_alarm with digits held stable
module aclock_setter #(
  parameter int unsigned LD_PULSE_CYC = 1,
  parameter int unsigned TIMEOUT_CYC  = 50000000
) (
  input logic            clk,
  input logic            reset,
  aclock_setter_if.master bus
);
  localparam logic [31:0] LD_LOAD = 32'(LD_PULSE_CYC - 1);
  localparam logic [31:0] TO_LOAD = 32'(TIMEOUT_CYC - 1);
  localparam bit          TO_EN   = (TIMEOUT_CYC != 0);

  typedef enum logic [2:0] {IDLE, EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0, LOAD} state_t;

  state_t      r_state;
  logic [4:0]  r_btn_q;
  logic [4:0]  r_press;
  logic [1:0]  r_h1;
  logic [3:0]  r_h0, r_m1, r_m0;
  logic [1:0]  r_al_h1;
  logic [3:0]  r_al_h0, r_al_m1, r_al_m0;
  logic [31:0] r_to_cnt;
  logic [31:0] r_ld_cnt;
  logic        r_ld_time, r_ld_alarm;
  logic        r_edit_active, r_edit_alarm;
  logic [1:0]  r_edit_digit;

  logic [4:0]  w_btn;
  logic        w_p_time, w_p_alarm, w_p_inc, w_p_next;
  logic        w_abort;
  logic [1:0]  w_h1_inc;
  logic [3:0]  w_h0_inc, w_m1_inc, w_m0_inc;

  assign w_btn     = {bus.btn_stop, bus.btn_next, bus.btn_inc, bus.btn_alarm, bus.btn_time};
  assign w_p_time  = r_press[0];
  assign w_p_alarm = r_press[1];
  assign w_p_inc   = r_press[2];
  assign w_p_next  = r_press[3];

  // Timeout only counts as an abort when no inc/next press is being accepted.
  assign w_abort = w_p_time | w_p_alarm |
                   (TO_EN && (r_to_cnt == 32'd0) && !w_p_next && !w_p_inc);

  // H0 upper bound depends on H1 so the hour never leaves 00..23.
  assign w_h1_inc = (r_h1 == 2'd2) ? 2'd0 : r_h1 + 2'd1;
  assign w_h0_inc = (r_h0 >= ((r_h1 == 2'd2) ? 4'd3 : 4'd9)) ? 4'd0 : r_h0 + 4'd1;
  assign w_m1_inc = (r_m1 >= 4'd5) ? 4'd0 : r_m1 + 4'd1;
  assign w_m0_inc = (r_m0 >= 4'd9) ? 4'd0 : r_m0 + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_btn_q       <= '0;
      r_press       <= '0;
      r_h1          <= '0;
      r_h0          <= '0;
      r_m1          <= '0;
      r_m0          <= '0;
      r_al_h1       <= '0;
      r_al_h0       <= '0;
      r_al_m1       <= '0;
      r_al_m0       <= '0;
      r_to_cnt      <= '0;
      r_ld_cnt      <= '0;
      r_ld_time     <= 1'b0;
      r_ld_alarm    <= 1'b0;
      r_edit_active <= 1'b0;
      r_edit_alarm  <= 1'b0;
      r_edit_digit  <= 2'd0;
    end else begin
      r_btn_q <= w_btn;
      r_press <= w_btn & ~r_btn_q;
      case (r_state)
        IDLE: begin
          // time press wins when both arrive together
          if (w_p_time || w_p_alarm) begin
            r_state       <= EDIT_H1;
            r_edit_active <= 1'b1;
            r_edit_digit  <= 2'd0;
            r_edit_alarm  <= !w_p_time;
            r_to_cnt      <= TO_LOAD;
            if (w_p_time) begin
              r_h1 <= bus.H_out1;
              r_h0 <= bus.H_out0;
              r_m1 <= bus.M_out1;
              r_m0 <= bus.M_out0;
            end else begin
              r_h1 <= r_al_h1;
              r_h0 <= r_al_h0;
              r_m1 <= r_al_m1;
              r_m0 <= r_al_m0;
            end
          end
        end
        EDIT_H1, EDIT_H0, EDIT_M1, EDIT_M0: begin
          if (w_abort) begin
            r_state       <= IDLE;
            r_edit_active <= 1'b0;
            r_edit_digit  <= 2'd0;
          end else if (w_p_next) begin
            r_to_cnt     <= TO_LOAD;
            r_edit_digit <= r_edit_digit + 2'd1;
            case (r_state)
              EDIT_H1: r_state <= EDIT_H0;
              EDIT_H0: r_state <= EDIT_M1;
              EDIT_M1: r_state <= EDIT_M0;
              default: begin
                r_state       <= LOAD;
                r_edit_active <= 1'b0;
                r_ld_cnt      <= LD_LOAD;
                r_ld_time     <= !r_edit_alarm;
                r_ld_alarm    <= r_edit_alarm;
              end
            endcase
          end else if (w_p_inc) begin
            r_to_cnt <= TO_LOAD;
            case (r_state)
              EDIT_H1: begin
                r_h1 <= w_h1_inc;
                if (w_h1_inc == 2'd2 && r_h0 > 4'd3) r_h0 <= 4'd3;
              end
              EDIT_H0: r_h0 <= w_h0_inc;
              EDIT_M1: r_m1 <= w_m1_inc;
              default: r_m0 <= w_m0_inc;
            endcase
          end else begin
            r_to_cnt <= r_to_cnt - 32'd1;
          end
        end
        LOAD: begin
          if (r_edit_alarm && r_ld_cnt == LD_LOAD) begin
            r_al_h1 <= r_h1;
            r_al_h0 <= r_h0;
            r_al_m1 <= r_m1;
            r_al_m0 <= r_m0;
          end
          if (r_ld_cnt == 32'd0) begin
            r_ld_time  <= 1'b0;
            r_ld_alarm <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_ld_cnt <= r_ld_cnt - 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.H_in1       = r_h1;
  assign bus.H_in0       = r_h0;
  assign bus.M_in1       = r_m1;
  assign bus.M_in0       = r_m0;
  assign bus.LD_time     = r_ld_time;
  assign bus.LD_alarm    = r_ld_alarm;
  assign bus.STOP_al     = r_press[4];
  assign bus.edit_active = r_edit_active;
  assign bus.edit_digit  = r_edit_digit;
  assign bus.edit_alarm  = r_edit_alarm;
endmodule

// File: tb/tb_aclock_setter.sv
module tb_aclock_setter;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  aclock_setter_if ifa ();
  aclock_setter_if ifb ();

  assign ifb.btn_time  = ifa.btn_time;
  assign ifb.btn_alarm = ifa.btn_alarm;
  assign ifb.btn_inc   = ifa.btn_inc;
  assign ifb.btn_next  = ifa.btn_next;
  assign ifb.btn_stop  = ifa.btn_stop;
  assign ifb.H_out1    = ifa.H_out1;
  assign ifb.H_out0    = ifa.H_out0;
  assign ifb.M_out1    = ifa.M_out1;
  assign ifb.M_out0    = ifa.M_out0;

  aclock_setter #(.LD_PULSE_CYC(1), .TIMEOUT_CYC(16)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  aclock_setter #(.LD_PULSE_CYC(4), .TIMEOUT_CYC(0))  dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  typedef struct packed {
    logic        al;
    logic [13:0] d;
  } exp_t;
  exp_t sb_q[$];

  int errors = 0;
  int checks = 0;

  int n_ld_time = 0, n_ld_alarm = 0, n_stop_cyc = 0, n_stop_rise = 0;
  logic stop_prev = 1'b0;
  always @(negedge clk) begin
    if (ifa.LD_time)  n_ld_time++;
    if (ifa.LD_alarm) n_ld_alarm++;
    if (ifa.STOP_al) n_stop_cyc++;
    if (ifa.STOP_al && !stop_prev) n_stop_rise++;
    stop_prev = ifa.STOP_al;
  end

  function automatic logic [13:0] mk(input int h1, input int h0, input int m1, input int m0);
    return {h1[1:0], h0[3:0], m1[3:0], m0[3:0]};
  endfunction

  function automatic logic [13:0] dig_a();
    return {ifa.H_in1, ifa.H_in0, ifa.M_in1, ifa.M_in0};
  endfunction

  function automatic logic [13:0] dig_b();
    return {ifb.H_in1, ifb.H_in0, ifb.M_in1, ifb.M_in0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask bits: 0 time, 1 alarm, 2 inc, 3 next, 4 stop
  task automatic set_btns(input logic [4:0] m);
    ifa.btn_time  = m[0];
    ifa.btn_alarm = m[1];
    ifa.btn_inc   = m[2];
    ifa.btn_next  = m[3];
    ifa.btn_stop  = m[4];
  endtask

  task automatic press(input logic [4:0] m);
    set_btns(m);
    tick();
    set_btns(5'b0);
    tick();
  endtask

  task automatic press_n(input logic [4:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  task automatic set_hout(input int h1, input int h0, input int m1, input int m0);
    {ifa.H_out1, ifa.H_out0, ifa.M_out1, ifa.M_out0} = mk(h1, h0, m1, m0);
  endtask

  task automatic capture_strobe(output bit got, output bit is_al, output logic [13:0] d,
                                output int width, output bit bad);
    got = 0; is_al = 0; d = '0; width = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifa.LD_time || ifa.LD_alarm) begin
        if (!got) begin
          got = 1;
          is_al = ifa.LD_alarm;
          d = dig_a();
        end
        if ((ifa.LD_time && ifa.LD_alarm) || dig_a() !== d) bad = 1;
        width++;
      end else if (got) begin
        break;
      end
      tick();
    end
  endtask

  task automatic commit_and_check(input string name);
    bit got, is_al, bad;
    logic [13:0] d;
    int width;
    exp_t e;
    press(5'b01000);
    capture_strobe(got, is_al, d, width, bad);
    e = sb_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_seen: no LD strobe within 20 cycles, expected one", name);
    end
    checks++;
    if (is_al !== e.al) begin
      errors++;
      $display("FAIL %s_kind: got alarm=%0b expected alarm=%0b", name, is_al, e.al);
    end
    checks++;
    if (d !== e.d) begin
      errors++;
      $display("FAIL %s_digits: got %h expected %h", name, d, e.d);
    end
    checks++;
    if (width !== 1 || bad !== 1'b0) begin
      errors++;
      $display("FAIL %s_width: got width=%0d unstable=%0b expected width=1 unstable=0", name, width, bad);
    end
  endtask

  task automatic test_reset();
    set_btns(5'b0);
    set_hout(0, 0, 0, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) tick();
    checks++;
    if (dig_a() !== 14'h0) begin
      errors++;
      $display("FAIL reset_digits: got %h expected 0", dig_a());
    end
    checks++;
    if ({ifa.LD_time, ifa.LD_alarm, ifa.STOP_al} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 000", {ifa.LD_time, ifa.LD_alarm, ifa.STOP_al});
    end
    checks++;
    if ({ifa.edit_active, ifa.edit_digit, ifa.edit_alarm} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_edit: got %b expected 0000", {ifa.edit_active, ifa.edit_digit, ifa.edit_alarm});
    end
    rst_a = 1'b0;
    tick();
    set_hout(1, 2, 3, 4);
    press(5'b00100);
    press(5'b01000);
    checks++;
    if (ifa.edit_active !== 1'b0 || dig_a() !== 14'h0) begin
      errors++;
      $display("FAIL idle_ignore: got active=%0b digits=%h expected 0 and 0", ifa.edit_active, dig_a());
    end
  endtask

  task automatic test_time_load();
    set_hout(1, 3, 4, 7);
    press(5'b00001);
    checks++;
    if ({ifa.edit_active, ifa.edit_digit, ifa.edit_alarm} !== 4'b1000 || dig_a() !== mk(1, 3, 4, 7)) begin
      errors++;
      $display("FAIL time_enter: got status=%b digits=%h expected 1000 and %h",
               {ifa.edit_active, ifa.edit_digit, ifa.edit_alarm}, dig_a(), mk(1, 3, 4, 7));
    end
    press_n(5'b01000, 3);
    checks++;
    if (ifa.edit_digit !== 2'd3) begin
      errors++;
      $display("FAIL time_digit_adv: got %0d expected 3", ifa.edit_digit);
    end
    sb_q.push_back('{al: 1'b0, d: mk(1, 3, 4, 7)});
    commit_and_check("time_load");
    checks++;
    if (ifa.edit_active !== 1'b0 || dig_a() !== mk(1, 3, 4, 7)) begin
      errors++;
      $display("FAIL time_after: got active=%0b digits=%h expected 0 and %h", ifa.edit_active, dig_a(), mk(1, 3, 4, 7));
    end
  endtask

  task automatic test_wrap();
    set_hout(1, 9, 5, 8);
    press(5'b00001);
    press(5'b00100);
    checks++;
    if (dig_a() !== mk(2, 3, 5, 8)) begin
      errors++;
      $display("FAIL wrap_h1_clamp: got %h expected %h", dig_a(), mk(2, 3, 5, 8));
    end
    press(5'b00100);
    checks++;
    if (dig_a() !== mk(0, 3, 5, 8)) begin
      errors++;
      $display("FAIL wrap_h1_zero: got %h expected %h", dig_a(), mk(0, 3, 5, 8));
    end
    press_n(5'b00100, 2);
    press(5'b01000);
    press(5'b00100);
    checks++;
    if (dig_a() !== mk(2, 0, 5, 8)) begin
      errors++;
      $display("FAIL wrap_h0_at3: got %h expected %h", dig_a(), mk(2, 0, 5, 8));
    end
    press_n(5'b00100, 3);
    press(5'b01000);
    press(5'b00100);
    checks++;
    if (dig_a() !== mk(2, 3, 0, 8)) begin
      errors++;
      $display("FAIL wrap_m1: got %h expected %h", dig_a(), mk(2, 3, 0, 8));
    end
    press_n(5'b00100, 5);
    press(5'b01000);
    press(5'b00100);
    checks++;
    if (dig_a() !== mk(2, 3, 5, 9)) begin
      errors++;
      $display("FAIL wrap_m0_9: got %h expected %h", dig_a(), mk(2, 3, 5, 9));
    end
    press(5'b00100);
    checks++;
    if (dig_a() !== mk(2, 3, 5, 0)) begin
      errors++;
      $display("FAIL wrap_m0_0: got %h expected %h", dig_a(), mk(2, 3, 5, 0));
    end
    sb_q.push_back('{al: 1'b0, d: mk(2, 3, 5, 0)});
    commit_and_check("wrap_load");
  endtask

  task automatic test_alarm();
    press(5'b00010);
    checks++;
    if (ifa.edit_alarm !== 1'b1 || dig_a() !== mk(0, 0, 0, 0)) begin
      errors++;
      $display("FAIL alarm_enter: got alarm=%0b digits=%h expected 1 and 0000", ifa.edit_alarm, dig_a());
    end
    press(5'b01000);
    press_n(5'b00100, 7);
    press(5'b01000);
    press_n(5'b00100, 3);
    press(5'b01000);
    sb_q.push_back('{al: 1'b1, d: mk(0, 7, 3, 0)});
    commit_and_check("alarm_load");
    press(5'b00010);
    checks++;
    if (dig_a() !== mk(0, 7, 3, 0)) begin
      errors++;
      $display("FAIL alarm_preload: got %h expected %h", dig_a(), mk(0, 7, 3, 0));
    end
  endtask

  task automatic test_abort();
    int t0, a0;
    bit dropped;
    t0 = n_ld_time;
    a0 = n_ld_alarm;
    press(5'b00100);
    press(5'b00010);
    checks++;
    if (ifa.edit_active !== 1'b0 || dig_a() !== mk(1, 7, 3, 0)) begin
      errors++;
      $display("FAIL abort_press: got active=%0b digits=%h expected 0 and %h", ifa.edit_active, dig_a(), mk(1, 7, 3, 0));
    end
    press(5'b00010);
    checks++;
    if (dig_a() !== mk(0, 7, 3, 0)) begin
      errors++;
      $display("FAIL abort_saved: got %h expected %h", dig_a(), mk(0, 7, 3, 0));
    end
    repeat (12) tick();
    checks++;
    if (ifa.edit_active !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got active=%0b expected 1", ifa.edit_active);
    end
    dropped = 0;
    for (int i = 0; i < 30; i++) begin
      if (!ifa.edit_active) begin
        dropped = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!dropped) begin
      errors++;
      $display("FAIL timeout_fire: edit_active still 1 after 30 cycles, expected 0");
    end
    checks++;
    if (n_ld_time !== t0 || n_ld_alarm !== a0) begin
      errors++;
      $display("FAIL abort_nostrobe: got ld cycles %0d/%0d expected %0d/%0d", n_ld_time, n_ld_alarm, t0, a0);
    end
    press(5'b00010);
    checks++;
    if (dig_a() !== mk(0, 7, 3, 0)) begin
      errors++;
      $display("FAIL timeout_saved: got %h expected %h", dig_a(), mk(0, 7, 3, 0));
    end
    press(5'b00001);
    checks++;
    if (ifa.edit_active !== 1'b0) begin
      errors++;
      $display("FAIL abort_time: got active=%0b expected 0", ifa.edit_active);
    end
  endtask

  task automatic test_stop();
    logic [13:0] d0;
    int r0, c0;
    set_hout(0, 5, 1, 2);
    press(5'b00001);
    press_n(5'b01000, 2);
    d0 = dig_a();
    r0 = n_stop_rise;
    c0 = n_stop_cyc;
    ifa.btn_stop = 1'b1;
    repeat (3) tick();
    ifa.btn_stop = 1'b0;
    repeat (2) tick();
    checks++;
    if (n_stop_rise - r0 !== 1 || n_stop_cyc - c0 !== 1) begin
      errors++;
      $display("FAIL stop_edit_pulse: got pulses=%0d cycles=%0d expected 1 and 1", n_stop_rise - r0, n_stop_cyc - c0);
    end
    checks++;
    if (ifa.edit_active !== 1'b1 || ifa.edit_digit !== 2'd2 || dig_a() !== d0) begin
      errors++;
      $display("FAIL stop_fsm_kept: got active=%0b digit=%0d digits=%h expected 1, 2, %h",
               ifa.edit_active, ifa.edit_digit, dig_a(), d0);
    end
    press(5'b00001);
    r0 = n_stop_rise;
    c0 = n_stop_cyc;
    ifa.btn_stop = 1'b1;
    repeat (20) tick();
    ifa.btn_stop = 1'b0;
    repeat (3) tick();
    checks++;
    if (n_stop_rise - r0 !== 1 || n_stop_cyc - c0 !== 1) begin
      errors++;
      $display("FAIL stop_hold: got pulses=%0d cycles=%0d expected 1 and 1", n_stop_rise - r0, n_stop_cyc - c0);
    end
  endtask

  task automatic test_priority();
    logic [13:0] d0;
    press(5'b00011);
    checks++;
    if (ifa.edit_active !== 1'b1 || ifa.edit_alarm !== 1'b0) begin
      errors++;
      $display("FAIL prio_time_wins: got active=%0b alarm=%0b expected 1 and 0", ifa.edit_active, ifa.edit_alarm);
    end
    press(5'b01000);
    d0 = dig_a();
    press(5'b01100);
    checks++;
    if (ifa.edit_digit !== 2'd2 || dig_a() !== d0) begin
      errors++;
      $display("FAIL prio_next_over_inc: got digit=%0d digits=%h expected 2 and %h", ifa.edit_digit, dig_a(), d0);
    end
    press(5'b01001);
    checks++;
    if (ifa.edit_active !== 1'b0 || ifa.LD_time !== 1'b0) begin
      errors++;
      $display("FAIL prio_abort_over_next: got active=%0b ld=%0b expected 0 and 0", ifa.edit_active, ifa.LD_time);
    end
  endtask

  task automatic test_reset_load();
    bit late;
    rst_b = 1'b0;
    tick();
    set_hout(1, 2, 3, 4);
    press(5'b00001);
    press_n(5'b01000, 4);
    checks++;
    if (ifb.LD_time !== 1'b1 || dig_b() !== mk(1, 2, 3, 4)) begin
      errors++;
      $display("FAIL long_strobe_start: got ld=%0b digits=%h expected 1 and %h", ifb.LD_time, dig_b(), mk(1, 2, 3, 4));
    end
    tick();
    checks++;
    if (ifb.LD_time !== 1'b1) begin
      errors++;
      $display("FAIL long_strobe_hold: got ld=%0b expected 1", ifb.LD_time);
    end
    #2 rst_b = 1'b1;
    #1;
    checks++;
    if ({ifb.LD_time, ifb.LD_alarm, ifb.STOP_al, ifb.edit_active, ifb.edit_digit, ifb.edit_alarm} !== 7'b0
        || dig_b() !== 14'h0) begin
      errors++;
      $display("FAIL async_reset_load: got ld=%0b digits=%h expected 0 and 0", ifb.LD_time, dig_b());
    end
    tick();
    rst_b = 1'b0;
    late = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifb.LD_time || ifb.LD_alarm) late = 1;
      tick();
    end
    checks++;
    if (late) begin
      errors++;
      $display("FAIL reset_no_resume: got strobe after reset, expected none");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_time_load();
    test_wrap();
    test_alarm();
    test_abort();
    test_stop();
    test_priority();
    test_reset_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
